wb_stage_p: RTL and testbench

Parametrised, registered write-back stage for the 8-bit core. It accepts one retired instruction per cycle from execute over a valid/ready handshake and decodes the opcode into single-cycle write strobes for the register file (narrow or wide), data memory and PC. It also implements a sticky HALT latch and a configurable branch-shadow squash counter. It replaces the purely combinational write-back decode with one registered pipeline stage.

---
 rtl/wb_stage_p.sv | 141 ++++++++++++++
 tb/tb_wb_stage_p.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_p.sv
// Registered write-back stage: decodes retired instructions into one-cycle rf/mem/pc strobes,
// with a sticky halt latch and branch-shadow squash. Optional retired counter: WB_RETIRE_CNT_EN.
module wb_stage_p #(
   parameter int DATA_W    = 8,
   parameter int RF_AW     = 3,
   parameter int MEM_AW    = 4,
   parameter int PC_W      = 6,
   parameter int BR_SHADOW = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4:0]            opcode,
   input  logic                  am,
   input  logic [RF_AW-1:0]      rd,
   input  logic [MEM_AW-1:0]     mem_addr,
   input  logic [PC_W-1:0]       target,
   input  logic [2*DATA_W-1:0]   alu_out,
   input  logic                  zero_flag,
   input  logic                  carry_flag,
   input  logic                  aux_flag,
   input  logic                  parity_flag,
   output logic                  rf_we,
   output logic                  rf_wide,
   output logic [RF_AW-1:0]      rf_waddr,
   output logic [2*DATA_W-1:0]   rf_wdata,
   output logic                  mem_we,
   output logic [MEM_AW-1:0]     mem_waddr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic                  pc_load,
   output logic [PC_W-1:0]       pc_target,
   output logic                  halted
`ifdef WB_RETIRE_CNT_EN
   ,output logic [15:0]          retired
`endif
);

   localparam logic [4:0] OP_MOVE = 5'b00000, OP_ADD  = 5'b00001, OP_SUB  = 5'b00010,
                          OP_MUL  = 5'b00011, OP_DIV  = 5'b00100, OP_INC  = 5'b00101,
                          OP_DEC  = 5'b00110, OP_AND  = 5'b00111, OP_OR   = 5'b01000,
                          OP_NOT  = 5'b01001, OP_XOR  = 5'b01010, OP_LOAD = 5'b01011,
                          OP_STORE= 5'b01100, OP_JUMP = 5'b01101, OP_BEQZ = 5'b01110,
                          OP_ASHL = 5'b10000, OP_ASHR = 5'b10001, OP_LSHL = 5'b10010,
                          OP_LSHR = 5'b10011, OP_ROTL = 5'b10100, OP_ROTR = 5'b10101,
                          OP_BC   = 5'b10110, OP_BAUX = 5'b10111, OP_BPAR = 5'b11000,
                          OP_CMP  = 5'b11001, OP_HALT = 5'b11111;

   localparam logic [1:0] SHADOW_INIT = 2'(BR_SHADOW);

   logic [1:0] shadow_cnt;
   logic       accept;
   logic       squash;
   logic       live;
   logic       nxt_rf_we;
   logic       nxt_rf_wide;
   logic       nxt_mem_we;
   logic       nxt_pc_load;
   logic       nxt_halt;

   assign in_ready = !halted;
   assign accept   = in_valid && in_ready;
   assign squash   = (shadow_cnt != 2'd0);
   assign live     = accept && !squash;

   always_comb begin
      nxt_rf_we   = 1'b0;
      nxt_rf_wide = 1'b0;
      nxt_mem_we  = 1'b0;
      nxt_pc_load = 1'b0;
      nxt_halt    = 1'b0;
      if (live) begin
         unique case (opcode)
            OP_MOVE, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP, OP_LOAD:
               nxt_rf_we = 1'b1;
            OP_MUL, OP_DIV: begin
               nxt_rf_we   = 1'b1;
               nxt_rf_wide = 1'b1;
            end
            OP_INC, OP_DEC, OP_NOT, OP_ASHL, OP_ASHR, OP_LSHL, OP_LSHR, OP_ROTL, OP_ROTR: begin
               nxt_mem_we = am;
               nxt_rf_we  = !am;
            end
            OP_STORE: nxt_mem_we  = 1'b1;
            OP_JUMP:  nxt_pc_load = 1'b1;
            OP_BEQZ:  nxt_pc_load = zero_flag;
            OP_BC:    nxt_pc_load = carry_flag;
            OP_BAUX:  nxt_pc_load = aux_flag;
            OP_BPAR:  nxt_pc_load = parity_flag;
            OP_HALT:  nxt_halt    = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we      <= 1'b0;
         rf_wide    <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
         mem_we     <= 1'b0;
         mem_waddr  <= '0;
         mem_wdata  <= '0;
         pc_load    <= 1'b0;
         pc_target  <= '0;
         halted     <= 1'b0;
         shadow_cnt <= 2'd0;
      end else begin
         rf_we   <= nxt_rf_we;
         rf_wide <= nxt_rf_wide;
         mem_we  <= nxt_mem_we;
         pc_load <= nxt_pc_load;
         // data/address registers only move with their strobe so they hold between writes
         if (nxt_rf_we) begin
            rf_waddr <= rd;
            rf_wdata <= alu_out;
         end
         if (nxt_mem_we) begin
            mem_waddr <= mem_addr;
            mem_wdata <= alu_out[DATA_W-1:0];
         end
         if (nxt_pc_load) pc_target <= target;
         if (nxt_halt) halted <= 1'b1;
         if (nxt_pc_load)
            shadow_cnt <= SHADOW_INIT;
         else if (accept && squash)
            shadow_cnt <= shadow_cnt - 2'd1;
      end
   end

`ifdef WB_RETIRE_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         retired <= 16'd0;
      else if (live)
         retired <= retired + 16'd1;
   end
`endif

endmodule

// File: tb/tb_wb_stage_p.sv
// Randomized + directed bench for wb_stage_p against an opcode-table reference model.
module tb_wb_stage_p;
   localparam int DATA_W = 8, RF_AW = 3, MEM_AW = 4, PC_W = 6, BRS = 2;

   logic clk = 1'b0;
   logic rst;
   logic in_valid, in_ready, am;
   logic [4:0] opcode;
   logic [RF_AW-1:0] rd;
   logic [MEM_AW-1:0] mem_addr;
   logic [PC_W-1:0] target;
   logic [2*DATA_W-1:0] alu_out;
   logic zero_flag, carry_flag, aux_flag, parity_flag;
   logic rf_we, rf_wide, mem_we, pc_load, halted;
   logic [RF_AW-1:0] rf_waddr;
   logic [2*DATA_W-1:0] rf_wdata;
   logic [MEM_AW-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [PC_W-1:0] pc_target;
`ifdef WB_RETIRE_CNT_EN
   logic [15:0] retired;
`endif

   always #5 clk = ~clk;

   wb_stage_p #(.DATA_W(DATA_W), .RF_AW(RF_AW), .MEM_AW(MEM_AW), .PC_W(PC_W), .BR_SHADOW(BRS)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .am(am),
      .rd(rd), .mem_addr(mem_addr), .target(target), .alu_out(alu_out),
      .zero_flag(zero_flag), .carry_flag(carry_flag), .aux_flag(aux_flag), .parity_flag(parity_flag),
      .rf_we(rf_we), .rf_wide(rf_wide), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .pc_load(pc_load), .pc_target(pc_target), .halted(halted)
`ifdef WB_RETIRE_CNT_EN
      , .retired(retired)
`endif
   );

   // opcode classes for the reference model
   localparam int C_NONE = 0, C_REG = 1, C_WIDE = 2, C_UNARY = 3, C_STORE = 4,
                  C_JUMP = 5, C_BR = 6, C_HALT = 7;
   int cls [32];
   int br_flag [32];

   int total = 0;
   int bad = 0;

   logic m_halted;
   int m_shadow;
   logic [15:0] m_retired;
   logic e_rf_we, e_rf_wide, e_mem_we, e_pc_load;
   logic [RF_AW-1:0] e_rf_waddr;
   logic [2*DATA_W-1:0] e_rf_wdata;
   logic [MEM_AW-1:0] e_mem_waddr;
   logic [DATA_W-1:0] e_mem_wdata;
   logic [PC_W-1:0] e_pc_target;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic present(input logic v, input logic [4:0] op, input logic a,
                          input logic [RF_AW-1:0] r, input logic [MEM_AW-1:0] ma,
                          input logic [PC_W-1:0] tg, input logic [15:0] alu, input logic [3:0] fl);
      in_valid = v; opcode = op; am = a; rd = r; mem_addr = ma; target = tg; alu_out = alu;
      {parity_flag, aux_flag, carry_flag, zero_flag} = fl;
   endtask

   task automatic model_edge();
      logic [3:0] fl;
      fl = {parity_flag, aux_flag, carry_flag, zero_flag};
      if (rst) begin
         m_halted = 0; m_shadow = 0; m_retired = 0;
         e_rf_we = 0; e_rf_wide = 0; e_mem_we = 0; e_pc_load = 0;
         e_rf_waddr = 0; e_rf_wdata = 0; e_mem_waddr = 0; e_mem_wdata = 0; e_pc_target = 0;
         return;
      end
      e_rf_we = 0; e_rf_wide = 0; e_mem_we = 0; e_pc_load = 0;
      if (!in_valid || m_halted) return;
      if (m_shadow > 0) begin
         m_shadow--;
         return;
      end
      m_retired = m_retired + 16'd1;
      case (cls[opcode])
         C_REG, C_WIDE: begin
            e_rf_we = 1; e_rf_wide = (cls[opcode] == C_WIDE);
            e_rf_waddr = rd; e_rf_wdata = alu_out;
         end
         C_UNARY, C_STORE: begin
            if (cls[opcode] == C_STORE || am) begin
               e_mem_we = 1; e_mem_waddr = mem_addr; e_mem_wdata = alu_out[7:0];
            end else begin
               e_rf_we = 1; e_rf_waddr = rd; e_rf_wdata = alu_out;
            end
         end
         C_JUMP, C_BR: begin
            if (cls[opcode] == C_JUMP || fl[br_flag[opcode]]) begin
               e_pc_load = 1; e_pc_target = target; m_shadow = BRS;
            end
         end
         C_HALT: m_halted = 1;
         default: ;
      endcase
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("rf_we", 32'(rf_we), 32'(e_rf_we));
      check("rf_wide", 32'(rf_wide), 32'(e_rf_wide));
      check("rf_waddr", 32'(rf_waddr), 32'(e_rf_waddr));
      check("rf_wdata", 32'(rf_wdata), 32'(e_rf_wdata));
      check("mem_we", 32'(mem_we), 32'(e_mem_we));
      check("mem_waddr", 32'(mem_waddr), 32'(e_mem_waddr));
      check("mem_wdata", 32'(mem_wdata), 32'(e_mem_wdata));
      check("pc_load", 32'(pc_load), 32'(e_pc_load));
      check("pc_target", 32'(pc_target), 32'(e_pc_target));
      check("halted", 32'(halted), 32'(m_halted));
      check("in_ready", 32'(in_ready), 32'(!m_halted));
`ifdef WB_RETIRE_CNT_EN
      check("retired", 32'(retired), 32'(m_retired));
`endif
   endtask

   task automatic do_reset();
      rst = 1;
      present(0, 5'd0, 0, '0, '0, '0, 16'h0, 4'h0);
      step();
      rst = 0;
   endtask

   initial begin
      foreach (cls[i]) begin cls[i] = C_NONE; br_flag[i] = 0; end
      foreach (cls[i]) if (i inside {0, 1, 2, 7, 8, 10, 25, 11}) cls[i] = C_REG;
      cls[3] = C_WIDE; cls[4] = C_WIDE;
      foreach (cls[i]) if (i inside {5, 6, 9, 16, 17, 18, 19, 20, 21}) cls[i] = C_UNARY;
      cls[12] = C_STORE; cls[13] = C_JUMP; cls[31] = C_HALT;
      cls[14] = C_BR; br_flag[14] = 0;
      cls[22] = C_BR; br_flag[22] = 1;
      cls[23] = C_BR; br_flag[23] = 2;
      cls[24] = C_BR; br_flag[24] = 3;

      rst = 1;
      present(0, 5'd0, 0, '0, '0, '0, 16'h0, 4'h0);
      step();
      step();
      rst = 0;
      check("rst_ready", 32'(in_ready), 32'd1);

      // ADD rd=3
      present(1, 5'b00001, 0, 3'd3, 4'd0, 6'd0, 16'h00A5, 4'h0); step();
      check("add_we", 32'(rf_we), 32'd1);
      check("add_wdata", 32'(rf_wdata), 32'h00A5);
      present(0, 5'b00001, 0, 3'd5, 4'd0, 6'd0, 16'hFFFF, 4'h0); step();
      check("hold_wdata", 32'(rf_wdata), 32'h00A5);
      // MUL, INC to memory
      present(1, 5'b00011, 0, 3'd2, 4'd0, 6'd0, 16'h1234, 4'h0); step();
      check("mul_wide", 32'(rf_wide), 32'd1);
      present(1, 5'b00101, 1, 3'd1, 4'd9, 6'd0, 16'h0042, 4'h0); step();
      check("inc_mem", 32'(mem_wdata), 32'h42);
      // BEQZ not taken then taken
      present(1, 5'b01110, 0, 3'd0, 4'd0, 6'h2A, 16'h0, 4'h0); step();
      check("beqz_nt", 32'(pc_load), 32'd0);
      present(1, 5'b01110, 0, 3'd0, 4'd0, 6'h2A, 16'h0, 4'h1); step();
      check("beqz_t", 32'(pc_target), 32'h2A);

      // JUMP then ADD, STORE, SUB with shadow=2
      do_reset();
      present(1, 5'b01101, 0, 3'd0, 4'd0, 6'd5, 16'h0, 4'h0); step();
      check("jump_load", 32'(pc_load), 32'd1);
      present(1, 5'b00001, 0, 3'd4, 4'd0, 6'd0, 16'h0011, 4'h0); step();
      check("sq_add", 32'(rf_we), 32'd0);
      present(1, 5'b01100, 0, 3'd0, 4'd3, 6'd0, 16'h0022, 4'h0); step();
      check("sq_store", 32'(mem_we), 32'd0);
      present(1, 5'b00010, 0, 3'd6, 4'd0, 6'd0, 16'h0033, 4'h0); step();
      check("sub_we", 32'(rf_we), 32'd1);
`ifdef WB_RETIRE_CNT_EN
      check("retired2", 32'(retired), 32'd2);
`endif

      // HALT then ADD
      present(1, 5'b11111, 0, 3'd0, 4'd0, 6'd0, 16'h0, 4'h0); step();
      check("halt_ready", 32'(in_ready), 32'd0);
      present(1, 5'b00001, 0, 3'd1, 4'd0, 6'd0, 16'h0099, 4'h0); step(); step();
      check("halt_noadd", 32'(rf_we), 32'd0);
      do_reset();
      check("unhalt", 32'(halted), 32'd0);

      // rst with accepted ADD
      rst = 1;
      present(1, 5'b00001, 0, 3'd3, 4'd0, 6'd0, 16'h00A5, 4'h0); step();
      rst = 0;
      check("rst_add", 32'(rf_wdata), 32'd0);

      // taken branch then HALT: HALT squashed
      present(1, 5'b10110, 0, 3'd0, 4'd0, 6'd7, 16'h0, 4'h2); step();
      present(1, 5'b11111, 0, 3'd0, 4'd0, 6'd0, 16'h0, 4'h0); step();
      check("halt_sq", 32'(halted), 32'd0);

      for (int n = 0; n < 600; n++) begin
         logic [4:0] op;
         op = ($urandom_range(0, 39) == 0) ? 5'b11111 : 5'($urandom_range(0, 30));
         rst = ($urandom_range(0, 29) == 0);
         present($urandom_range(0, 3) != 0, op, 1'($urandom), 3'($urandom), 4'($urandom),
                 6'($urandom), 16'($urandom), 4'($urandom));
         step();
      end
      rst = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
